// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter and strobe sequencer for a single asynchronous
// external SRAM shared by two requesters (port 0 and port 1).
// Each access is IDLE (grant) -> ACCESS (strobe held ACCESS_CYCLES cycles) -> RECOVER
// (both strobes low, one-cycle ack) -> IDLE. Every output comes straight from a flop.
module sram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned ADDR_W        = 18,
  parameter int unsigned DATA_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Strobe length counter: ACCESS_CYCLES is limited to 1..15.
  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // Request payload presented by one port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  // Port granted most recently; during ACCESS it is also the port being served.
  logic              last_grant;
  logic              last_grant_nxt;

  logic              req_any_c;
  logic              grant_sel_c;
  req_t              req0_c;
  req_t              req1_c;
  req_t              grant_req_c;

  logic              mem_read_nxt;
  logic              mem_write_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] rdata0_nxt;
  logic [DATA_W-1:0] rdata1_nxt;
  logic              ack0_nxt;
  logic              ack1_nxt;
  logic              busy_nxt;

  // Round-robin choice: a lone requester wins, on conflict the port not granted last wins.
  always_comb begin
    req0_c      = '{we: we0, addr: addr0, wdata: wdata0};
    req1_c      = '{we: we1, addr: addr1, wdata: wdata1};
    req_any_c   = req0 | req1;
    grant_sel_c = (req0 & req1) ? ~last_grant : req1;
    grant_req_c = grant_sel_c ? req1_c : req0_c;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_any_c) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) begin
          state_nxt = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output/datapath next values; strobes default low so they can only be high in ACCESS.
  always_comb begin
    mem_read_nxt   = 1'b0;
    mem_write_nxt  = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    busy_nxt       = (state_nxt != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (req_any_c) begin
          mem_addr_nxt   = grant_req_c.addr;
          mem_wdata_nxt  = grant_req_c.wdata;
          mem_read_nxt   = ~grant_req_c.we;
          mem_write_nxt  = grant_req_c.we;
          cnt_nxt        = CNT_LOAD;
          last_grant_nxt = grant_sel_c;
        end
      end
      ST_ACCESS: begin
        if (cnt != '0) begin
          mem_read_nxt  = mem_read;
          mem_write_nxt = mem_write;
          cnt_nxt       = cnt - CNT_ONE;
        end else begin
          // Last strobe cycle: read data is valid now, capture it for the served port.
          if (mem_read) begin
            if (last_grant) begin
              rdata1_nxt = mem_rdata;
            end else begin
              rdata0_nxt = mem_rdata;
            end
          end
          if (last_grant) begin
            ack1_nxt = 1'b1;
          end else begin
            ack0_nxt = 1'b1;
          end
        end
      end
      ST_RECOVER: begin
        // Bus turnaround: strobes already low, ack pulse ends here.
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else begin
      mem_read   <= mem_read_nxt;
      mem_write  <= mem_write_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      busy       <= busy_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer in front of the sram pin-level module (18-bit address, 16-bit data, asynchronous external SRAM).
- Shares the single SRAM between requester 0 (e.g. CPU/PRG side) and requester 1 (e.g. PPU/CHR side).
- Arbitrates with round-robin fairness and drives the sram read/write strobes for a fixed, parameterised number of cycles.
- Captures read data and returns one-cycle acknowledges.

Parameters:
- ACCESS_CYCLES, 1: clock cycles the read/write strobe is held per access (1 = 83 ns at 12 MHz); legal range 1..15.
- ADDR_W, 18: address width.
- DATA_W, 16: data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 request; level, held until ack0.
- we0  in  1  port 0 write (1) / read (0); stable while req0.
- addr0  in  ADDR_W  port 0 address; stable while req0.
- wdata0  in  DATA_W  port 0 write data; stable while req0.
- rdata0  out  DATA_W  port 0 read data.
- ack0  out  1  port 0 completion pulse.
- req1, we1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1.
- mem_read  out  1  to sram read.
- mem_write  out  1  to sram write.
- mem_addr  out  ADDR_W  to sram address.
- mem_wdata  out  DATA_W  to sram data_write.
- mem_rdata  in  DATA_W  from sram data_read.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, state=IDLE, last_grant=1 (port 0 wins the first conflict), cnt=0.
- All outputs are registered; no combinational path from req* to mem_*.

FSM: IDLE -> ACCESS -> RECOVER -> IDLE.

IDLE:
- If neither req is high, stay in IDLE.
- If exactly one req is high, grant that port.
- If both are high, grant the port != last_grant.
- On grant:
  - Latch addr, wdata and we into mem_addr and mem_wdata.
  - Set mem_read = !we or mem_write = we.
  - Set cnt = ACCESS_CYCLES-1, update last_grant, go to ACCESS.

ACCESS:
- The strobe stays asserted; mem_addr and mem_wdata are held.
- If cnt != 0, decrement cnt.
- If cnt == 0:
  - Deassert both strobes.
  - If the access is a read, latch mem_rdata into rdata of the granted port.
  - Set ack of the granted port to 1 and go to RECOVER.

RECOVER:
- One cycle with both strobes low (bus turnaround, WE high between back-to-back writes).
- ack is high during this cycle only; next state is IDLE.

Timing and handshake:
- Latency: req sampled in IDLE at cycle 0; strobe high in cycles 1..ACCESS_CYCLES; ack in cycle ACCESS_CYCLES+1. Default gives ack at cycle 2.
- Throughput: one access per ACCESS_CYCLES+2 cycles.
- Requester drops req on the edge where it sees ack. If req is still high in the following IDLE cycle, it is treated as a new request.
- rdataN holds its value until the next completed read by port N. Writes do not modify rdataN.

Boundary rules:
- mem_read and mem_write are never high simultaneously.
- Neither strobe is ever high outside ACCESS.
- A req arriving while busy waits; it is never dropped.
- With both ports requesting continuously, grants strictly alternate.
- Reset mid-ACCESS or mid-RECOVER: at the next edge all outputs take reset values and the in-flight ack is suppressed. The requester must reissue the access.
- req deasserted before ack (protocol violation): the in-flight access still completes and acks.

Test Plan:
- Single read: preload SRAM model addr 0x00123 = 0xBEEF; port 0 read with req0 at cycle 0 -> mem_read high cycle 1 only, mem_addr=0x00123, ack0 cycle 2, rdata0=0xBEEF, ack1 never.
- Single write: port 1 writes 0x5A5A to 0x3FFFF -> mem_write high 1 cycle with mem_wdata=0x5A5A, mem_addr=0x3FFFF, ack1 cycle 2, model holds 0x5A5A, rdata1 unchanged.
- Simultaneous: req0 and req1 both high from reset release, each re-requesting after every ack, 6 accesses -> grant order 0,1,0,1,0,1, one ack per 3 cycles, no overlap of strobes.
- ACCESS_CYCLES=3 read -> mem_read high exactly cycles 1-3, ack at cycle 4, data sampled at end of cycle 3.
- Reset asserted in the strobe cycle of a port 0 write -> next cycle mem_write=0, busy=0, ack0 never pulses; a fresh req0 afterwards completes normally.
- Back-to-back writes by port 0 to 0x00010 and 0x00011 -> mem_write low for at least 2 cycles between the two strobes (RECOVER+IDLE), both values present in the model.
